// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter (SLL/SRL/SRA/ROR), one register
// stage per shift-amount bit, valid/ready handshake on both sides.
module shift_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic [SHW-1:0]   valid_q, valid_d;
  logic [WIDTH-1:0] data_q [SHW];
  logic [WIDTH-1:0] data_d [SHW];
  logic [SHW-1:0]   amt_q  [SHW];
  logic [SHW-1:0]   amt_d  [SHW];
  logic [1:0]       op_q   [SHW];
  logic [1:0]       op_d   [SHW];

  logic [SHW-1:0]   ready;
  logic [SHW-1:0]   src_v;
  logic [WIDTH-1:0] src_d [SHW];
  logic [SHW-1:0]   src_a [SHW];
  logic [1:0]       src_o [SHW];

  // The last stage's amount/op are carried for uniformity but never consumed.
  logic unused_tail;
  assign unused_tail = ^{amt_q[SHW-1], op_q[SHW-1]};

  // One stage's shift by s (0 or 2^k); SRA replicates the operand MSB.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] x,
                                                  input logic [1:0]       op,
                                                  input int unsigned      s);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = x << s;
      OP_SRL:  r = x >> s;
      OP_SRA:  r = WIDTH'($signed(x) >>> s);
      default: r = (x >> s) | (x << (WIDTH - s));
    endcase
    return r;
  endfunction

  // Combinational ready chain: a stage can load if empty or if its successor can.
  always_comb begin : ready_chain
    logic r;
    r     = out_ready;
    ready = '0;
    for (int unsigned i = 0; i < SHW; i++) begin
      r = ~valid_q[SHW-1-i] | r;
      ready[SHW-1-i] = r;
    end
  end

  // Source of each stage: stage 0 from the input port, others from predecessor.
  always_comb begin
    src_v[0] = in_valid & ready[0];
    src_d[0] = in_data;
    src_a[0] = in_amt;
    src_o[0] = in_op;
    for (int unsigned k = 1; k < SHW; k++) begin
      src_v[k] = valid_q[k-1];
      src_d[k] = data_q[k-1];
      src_a[k] = amt_q[k-1];
      src_o[k] = op_q[k-1];
    end
  end

  // Next state: load shifted source when ready, otherwise hold.
  always_comb begin
    for (int unsigned k = 0; k < SHW; k++) begin
      valid_d[k] = valid_q[k];
      data_d[k]  = data_q[k];
      amt_d[k]   = amt_q[k];
      op_d[k]    = op_q[k];
      if (ready[k]) begin
        valid_d[k] = src_v[k];
        if (src_v[k]) begin
          data_d[k] = shift_step(src_d[k], src_o[k],
                                 32'(src_a[k] & (SHW'(1) << k)));
          amt_d[k]  = src_a[k];
          op_d[k]   = src_o[k];
        end
      end
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < SHW; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        op_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned k = 0; k < SHW; k++) begin
        data_q[k] <= data_d[k];
        amt_q[k]  <= amt_d[k];
        op_q[k]   <= op_d[k];
      end
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_zero  = (data_q[SHW-1] == '0);

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed self-checking bench for shift_pipe (WIDTH=32 and WIDTH=8).
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_op;

  logic        v8, ir8, ov8, or8, oz8;
  logic [7:0]  d8, od8;
  logic [2:0]  a8;
  logic [1:0]  op8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero)
  );

  shift_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(v8), .in_ready(ir8), .in_data(d8),
    .in_amt(a8), .in_op(op8),
    .out_valid(ov8), .out_ready(or8),
    .out_data(od8), .out_zero(oz8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op on an idle pipeline and wait (bounded) for its result.
  task automatic run_op(input string tag, input bit w8, input logic [1:0] op,
                        input logic [31:0] data, input logic [4:0] amt,
                        input logic [31:0] exp, input int lat);
    int n;
    bit got;
    @(negedge clk);
    if (w8) begin
      v8 = 1'b1; op8 = op; d8 = data[7:0]; a8 = amt[2:0];
    end else begin
      in_valid = 1'b1; in_op = op; in_data = data; in_amt = amt;
    end
    @(negedge clk);
    v8 = 1'b0;
    in_valid = 1'b0;
    n = 1;
    got = 1'b0;
    while (n < 20 && !got) begin
      if (w8 ? ov8 : out_valid) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check({tag, "_seen"}, 64'(got), 64'd1);
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_data"}, w8 ? {56'd0, od8} : {32'd0, out_data}, {32'd0, exp});
    check({tag, "_zero"}, 64'(w8 ? oz8 : out_zero), 64'(exp == 32'd0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sexp [8];
    int  sent, rcv;
    bit  dropped, stale;
    sexp = '{32'h7FFFFFF0, 32'h3FFFFFF8, 32'h1FFFFFFC, 32'h0FFFFFFE,
             32'h07FFFFFF, 32'h03FFFFFF, 32'h01FFFFFF, 32'h00FFFFFF};

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b1;
    v8 = 1'b0; d8 = '0; a8 = '0; op8 = '0; or8 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ovalid", 64'(out_valid), 64'd0);
    check("rst_odata", {32'd0, out_data}, 64'd0);
    check("rst_ozero", 64'(out_zero), 64'd1);
    check("rst_iready", 64'(in_ready), 64'd1);
    check("rst_ozero8", 64'(oz8), 64'd1);
    rst = 1'b0;

    run_op("sra4", 1'b0, 2'b10, 32'h80000000, 5'd4, 32'hF8000000, 5);

    // Back-to-back SRL / SLL / ROR, results on consecutive cycles.
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'b01; in_data = 32'h80000000; in_amt = 5'd4;
    @(negedge clk);
    in_op = 2'b00; in_data = 32'h00000001; in_amt = 5'd31;
    @(negedge clk);
    in_op = 2'b11; in_data = 32'h00000001; in_amt = 5'd1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b0_valid", 64'(out_valid), 64'd1);
    check("b2b0_data", {32'd0, out_data}, 64'h08000000);
    @(negedge clk);
    check("b2b1_valid", 64'(out_valid), 64'd1);
    check("b2b1_data", {32'd0, out_data}, 64'h80000000);
    @(negedge clk);
    check("b2b2_valid", 64'(out_valid), 64'd1);
    check("b2b2_data", {32'd0, out_data}, 64'h80000000);

    // Stream 8 SRA ops with out_ready low for cycles 3..9.
    sent = 0; rcv = 0; dropped = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 9);
      if (sent < 8) begin
        in_valid = 1'b1; in_op = 2'b10; in_data = 32'h7FFFFFF0; in_amt = sent[4:0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        if (rcv >= 8) check("stream_extra", 64'd1, 64'd0);
        else if (out_ready) begin
          check("stream_res", {32'd0, out_data}, {32'd0, sexp[rcv]});
          rcv++;
        end else begin
          check("stall_hold", {32'd0, out_data}, {32'd0, sexp[rcv]});
        end
      end
      if (!in_ready && !dropped) begin
        dropped = 1'b1;
        check("inrdy_occ", 64'(sent - rcv), 64'd5);
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_cnt", 64'(rcv), 64'd8);
    check("inrdy_dropped", 64'(dropped), 64'd1);

    for (int unsigned m = 0; m < 4; m++)
      run_op("amt0", 1'b0, 2'(m), 32'hA5A5A5A5, 5'd0, 32'hA5A5A5A5, 5);
    run_op("srl_zero", 1'b0, 2'b01, 32'h00000001, 5'd1, 32'h00000000, 5);
    run_op("sra31", 1'b0, 2'b10, 32'h80000001, 5'd31, 32'hFFFFFFFF, 5);

    // Reset with three ops in flight.
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'b00; in_data = 32'h1; in_amt = 5'd1;
    @(negedge clk);
    in_amt = 5'd2;
    @(negedge clk);
    in_amt = 5'd3;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_ovalid", 64'(out_valid), 64'd0);
    check("rstmid_iready", 64'(in_ready), 64'd1);
    check("rstmid_odata", {32'd0, out_data}, 64'd0);
    stale = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("rstmid_stale", 64'(stale), 64'd0);

    run_op("sra8", 1'b1, 2'b10, 32'h90, 5'd3, 32'hF2, 3);
    run_op("ror8", 1'b1, 2'b11, 32'h81, 5'd7, 32'h03, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
